// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - frontend/decode shared types used by the fetch entry FIFO
package ariane_pkg;

  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    cf_t         cf;
    logic [63:0] predict_address;
  } branchpredict_sbe_t;

  // One realigned instruction plus its predict and fault metadata
  typedef struct packed {
    logic [63:0]        address;
    logic [31:0]        instruction;
    branchpredict_sbe_t branch_predict;
    exception_t         ex;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_entry_fifo.sv
// rtl/fetch_entry_fifo.sv - registered FIFO between the frontend realigner and decode
module fetch_entry_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  fetch_entry_t             fetch_entry_i,
  input  logic                     fetch_entry_valid_i,
  output logic                     fetch_entry_ready_o,
  output fetch_entry_t             fetch_entry_o,
  output logic                     fetch_entry_valid_o,
  input  logic                     fetch_entry_ready_i,
  output logic [$clog2(DEPTH):0]   usage_o,
  output logic                     almost_full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT   = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] ALMOST_CNT = (PTR_W + 1)'(DEPTH - 1);

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   usage_q;
  fetch_entry_t     mem_q [DEPTH];
  logic             push, pop;

  // Flush masks both handshakes so nothing moves in the flush cycle
  assign fetch_entry_ready_o = (usage_q != FULL_CNT) && !flush_i;
  assign fetch_entry_valid_o = (usage_q != '0) && !flush_i;
  assign fetch_entry_o       = mem_q[rd_ptr_q];
  assign usage_o             = usage_q;
  assign almost_full_o       = usage_q >= ALMOST_CNT;

  assign push = fetch_entry_valid_i && fetch_entry_ready_o;
  assign pop  = fetch_entry_valid_o && fetch_entry_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      usage_q <= usage_q + 1'b1;
      else if (pop && !push) usage_q <= usage_q - 1'b1;
    end
  end

  // Storage is never cleared; only pointers and count carry state
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) mem_q[wr_ptr_q] <= fetch_entry_i;
  end

endmodule

// File: tb/tb_fetch_entry_fifo.sv
// tb/tb_fetch_entry_fifo.sv - table vectors plus queue scoreboard for fetch_entry_fifo
module tb_fetch_entry_fifo;
  import ariane_pkg::*;

  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_ni, flush_i, fetch_entry_valid_i, fetch_entry_ready_i;
  logic             fetch_entry_ready_o, fetch_entry_valid_o, almost_full_o;
  fetch_entry_t     fetch_entry_i, fetch_entry_o;
  logic [2:0]       usage_o;

  fetch_entry_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .fetch_entry_i      (fetch_entry_i),
    .fetch_entry_valid_i(fetch_entry_valid_i),
    .fetch_entry_ready_o(fetch_entry_ready_o),
    .fetch_entry_o      (fetch_entry_o),
    .fetch_entry_valid_o(fetch_entry_valid_o),
    .fetch_entry_ready_i(fetch_entry_ready_i),
    .usage_o            (usage_o),
    .almost_full_o      (almost_full_o)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  fetch_entry_t  sb[$];
  logic [31:0]   next_pc = 32'h8000_0000;
  logic [31:0]   seq = 32'd1;
  logic [2:0]    s_usage;
  logic          s_rdy, s_vld, s_af;

  typedef struct {
    logic v, r, f;
    logic [2:0] usage;
    logic rdy, vld, af;
  } vec_t;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic fetch_entry_t make_entry(input logic [31:0] pc, input logic [31:0] id);
    fetch_entry_t e;
    e.address                        = {32'h0, pc};
    e.instruction                    = id;
    e.branch_predict.cf              = cf_t'(3'(id % 5));
    e.branch_predict.predict_address = {$urandom, $urandom};
    e.ex.cause                       = {$urandom, $urandom};
    e.ex.tval                        = {$urandom, $urandom};
    e.ex.valid                       = id[0];
    return e;
  endfunction

  // One clock: drive, compare against the queue model at negedge, then advance the model
  task automatic step(input logic v, input logic r, input logic f, input logic rs);
    fetch_entry_t e;
    logic exp_rdy, exp_vld;
    e = make_entry(next_pc, seq);
    seq = seq + 1;
    fetch_entry_valid_i = v;
    fetch_entry_ready_i = r;
    flush_i             = f;
    rst_ni              = rs;
    fetch_entry_i       = e;
    @(negedge clk);
    exp_rdy = (sb.size() < DEPTH) && !f;
    exp_vld = (sb.size() != 0) && !f;
    s_usage = usage_o;
    s_rdy   = fetch_entry_ready_o;
    s_vld   = fetch_entry_valid_o;
    s_af    = almost_full_o;
    chk("ready_o", 512'(fetch_entry_ready_o), 512'(exp_rdy));
    chk("valid_o", 512'(fetch_entry_valid_o), 512'(exp_vld));
    chk("usage_o", 512'(usage_o), 512'(sb.size()));
    chk("almost_full_o", 512'(almost_full_o), 512'(sb.size() >= DEPTH - 1));
    if (exp_vld && fetch_entry_valid_o) chk("entry_o", 512'(fetch_entry_o), 512'(sb[0]));
    @(posedge clk);
    #1;
    if (!rs || f) sb.delete();
    else begin
      if (exp_vld && r) void'(sb.pop_front());
      if (v && exp_rdy) begin
        sb.push_back(e);
        next_pc = next_pc + 32'd4;
      end
    end
  endtask

  vec_t vecs[16];

  initial begin
    // fill/drain, full-with-pop, then flush with a pending push
    vecs[0]  = '{1,0,0, 3'd0, 1,0,0};
    vecs[1]  = '{1,0,0, 3'd1, 1,1,0};
    vecs[2]  = '{1,0,0, 3'd2, 1,1,0};
    vecs[3]  = '{1,0,0, 3'd3, 1,1,1};
    vecs[4]  = '{0,0,0, 3'd4, 0,1,1};
    vecs[5]  = '{1,1,0, 3'd4, 0,1,1};
    vecs[6]  = '{0,1,0, 3'd3, 1,1,1};
    vecs[7]  = '{0,1,0, 3'd2, 1,1,0};
    vecs[8]  = '{0,1,0, 3'd1, 1,1,0};
    vecs[9]  = '{0,0,0, 3'd0, 1,0,0};
    vecs[10] = '{1,0,0, 3'd0, 1,0,0};
    vecs[11] = '{1,0,0, 3'd1, 1,1,0};
    vecs[12] = '{1,0,0, 3'd2, 1,1,0};
    vecs[13] = '{1,0,1, 3'd3, 0,0,1};
    vecs[14] = '{0,0,0, 3'd0, 1,0,0};
    vecs[15] = '{1,1,0, 3'd0, 1,0,0};

    rst_ni = 1'b0; flush_i = 1'b0; fetch_entry_valid_i = 1'b0; fetch_entry_ready_i = 1'b0;
    fetch_entry_i = make_entry(32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("reset_usage", 512'(usage_o), 512'(0));
    chk("reset_valid", 512'(fetch_entry_valid_o), 512'(0));
    chk("reset_ready", 512'(fetch_entry_ready_o), 512'(1));
    chk("reset_af", 512'(almost_full_o), 512'(0));
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].v, vecs[i].r, vecs[i].f, 1'b1);
      chk($sformatf("vec%0d_usage", i), 512'(s_usage), 512'(vecs[i].usage));
      chk($sformatf("vec%0d_ready", i), 512'(s_rdy), 512'(vecs[i].rdy));
      chk($sformatf("vec%0d_valid", i), 512'(s_vld), 512'(vecs[i].vld));
      chk($sformatf("vec%0d_af", i), 512'(s_af), 512'(vecs[i].af));
    end
    step(0, 1, 0, 1);

    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 1);
      if (i > 0) chk("stream_usage", 512'(s_usage), 512'(1));
    end
    step(0, 1, 0, 1);

    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 3; j++) step(1, 0, 0, 1);
      for (int j = 0; j < 3; j++) step(0, 1, 0, 1);
    end
    chk("wrap_empty", 512'(usage_o), 512'(0));

    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 1, 0, 1'b0);
    @(negedge clk);
    chk("rst_mid_usage", 512'(usage_o), 512'(0));
    chk("rst_mid_valid", 512'(fetch_entry_valid_o), 512'(0));
    chk("rst_mid_ready", 512'(fetch_entry_ready_o), 512'(1));
    chk("rst_mid_af", 512'(almost_full_o), 512'(0));
    @(posedge clk);
    #1;

    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 49) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_entry_fifo.md
FETCH_ENTRY_FIFO -- requirements
Module: fetch_entry_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of fetch-entry slots; SHALL be a power of two, >= 2.
REQ-002 Port clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 Port flush_i  input  1  discard all buffered entries (controller flush).
REQ-005 Port fetch_entry_i  input  ariane_pkg::fetch_entry_t  entry from the frontend realigner.
REQ-006 Port fetch_entry_valid_i  input  1  fetch_entry_i is valid.
REQ-007 Port fetch_entry_ready_o  output  1  FIFO accepts fetch_entry_i this cycle.
REQ-008 Port fetch_entry_o  output  ariane_pkg::fetch_entry_t  head entry to the decode stage.
REQ-009 Port fetch_entry_valid_o  output  1  fetch_entry_o is valid.
REQ-010 Port fetch_entry_ready_i  input  1  decode stage consumes the head entry.
REQ-011 Port usage_o  output  $clog2(DEPTH)+1  number of occupied slots.
REQ-012 Port almost_full_o  output  1  usage_o >= DEPTH-1; frontend throttle hint.

Function
REQ-013 Push SHALL occur when fetch_entry_valid_i && fetch_entry_ready_o; pop SHALL occur when fetch_entry_valid_o && fetch_entry_ready_i.
REQ-014 fetch_entry_ready_o SHALL equal (usage_o != DEPTH) && !flush_i, combinationally; no dependence on fetch_entry_ready_i (no full pass-through).
REQ-015 fetch_entry_valid_o SHALL equal (usage_o != 0) && !flush_i; fetch_entry_o SHALL be the storage slot at the read pointer.
REQ-016 Latency: an entry pushed in cycle N SHALL be visible on fetch_entry_o in cycle N+1 at the earliest; no combinational bypass from input to output.
REQ-017 Entries SHALL be delivered in push order, bit-exact, including the exception and branch-predict fields.
REQ-018 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without gaps.
REQ-019 usage_o next value: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
REQ-020 Simultaneous push and pop SHALL be allowed whenever 0 < usage_o < DEPTH; when full, only pop SHALL occur; when empty, only push SHALL occur.
REQ-021 While fetch_entry_valid_o is high and fetch_entry_ready_i is low, fetch_entry_o SHALL hold stable.
REQ-022 flush_i high SHALL, at the next edge, set usage_o to 0 and both pointers to 0; no push or pop SHALL occur in the flush cycle.
REQ-023 Storage contents need no clearing on flush or reset; only pointers and count are state-bearing.
REQ-024 Push of an entry whose ex.valid is set SHALL be treated as a normal entry; the FIFO SHALL NOT interpret entry contents.

Reset
REQ-025 When rst_ni is low at a rising edge, usage_o, read pointer and write pointer SHALL become 0.
REQ-026 Reset SHALL override flush_i and any handshake in the same cycle; an in-flight push in that cycle SHALL be lost.
REQ-027 Following reset: fetch_entry_valid_o=0, fetch_entry_ready_o=1 (flush_i low), almost_full_o=0.

Structure
REQ-028 fetch_entry_t SHALL be the existing ariane_pkg type; no new package typedefs are required.
REQ-029 The block SHALL be self-contained: pointer/count logic plus a DEPTH-entry register array; no sub-module.

Verification
REQ-030 Fill/drain: ready_i=0, push 4 entries with pc 0x80000000..0x8000000C -> usage_o=4, ready_o=0, almost_full_o=1 from usage 3; then ready_i=1 -> pcs emerge in order, one per cycle.
REQ-031 Streaming: valid_i=1 and ready_i=1 every cycle for 20 entries -> after the first cycle, usage_o stays at 1 and output order matches input order.
REQ-032 Wrap-around: 10 rounds of push 3 / pop 3 -> no loss or duplication; pointers wrap through slot 3 to 0.
REQ-033 Full with pop: usage 4, valid_i=1, ready_i=1 -> pop only, usage 3; the input entry is not accepted until the next cycle.
REQ-034 Flush mid-stream: usage 3, flush_i=1 with valid_i=1 -> ready_o=0 and valid_o=0 in that cycle; the next cycle has usage 0 and the dropped entry never appears.
REQ-035 Reset mid-operation: usage 2, rst_ni=0 for 1 cycle -> usage_o=0, valid_o=0, ready_o=1 afterwards.
